md_sched: RTL and testbench

- Issue scheduler and interlock for the multiply/divide unit (HI/LO unit) in the EX stage of the 5-stage MIPS pipeline.
- Accepts mult/div/mthi/mtlo/msub requests from EX and drives the unit's start/op/operand inputs.
- Models the unit's occupancy with its own latency counter and holds one accepted request in a 1-entry pending slot.
- Generates the pipeline stall for structural hazards and for mfhi/mflo read-after-write on HI/LO.

---
 rtl/md_sched_pkg.sv | 34 +++
 rtl/md_lat_cnt.sv | 36 +++
 rtl/md_sched.sv | 147 ++++++++++++++
 tb/tb_md_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the HI/LO (multiply/divide) unit scheduler.
// Op codes are common to the scheduler and the arithmetic unit itself.
package md_sched_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MSUB  = 3'd6;
    localparam logic [2:0] OP_NONE  = 3'd7;

    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;
    localparam int unsigned MOV_LAT_DEF = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StRunP = 2'd2
    } md_state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    function automatic logic op_valid(input logic [2:0] op);
        return op != OP_NONE;
    endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Occupancy counter for the HI/LO unit: loads the op latency on a start pulse
// and counts down to zero, flagging the last busy cycle.
module md_lat_cnt #(
    parameter int unsigned CntW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CntW-1:0] lat,
    output logic            free_next,
    output logic            zero
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = lat;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero      = (cnt_q == '0);
    assign free_next = (cnt_q == CntW'(1));

endmodule

// File: rtl/md_sched.sv
// Issue scheduler and interlock for the EX-stage HI/LO unit: one op in flight,
// one pending slot, and the stall for structural and HI/LO read hazards.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned MOV_LAT = MOV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        rd_req,
    input  logic        flush,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic        md_idle
);

    localparam int unsigned MaxLat01 = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned MaxLat   = (MaxLat01 > MOV_LAT) ? MaxLat01 : MOV_LAT;
    localparam int unsigned CntW     = $clog2(MaxLat + 1);

    function automatic logic [CntW-1:0] lat_of(input logic [2:0] op);
        case (op)
            OP_DIV, OP_DIVU:  return CntW'(DIV_LAT);
            OP_MTHI, OP_MTLO: return CntW'(MOV_LAT);
            default:          return CntW'(MUL_LAT);
        endcase
    endfunction

    md_state_e   state_q, state_d;
    md_req_t     pend_q, pend_d;
    logic        start_q, start_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic            cnt_free_next;
    logic            cnt_zero;
    logic [CntW-1:0] start_lat;
    logic            op_ok;
    logic            req_accept;
    logic            unit_free;

    assign start_lat = lat_of(op_q);

    md_lat_cnt #(
        .CntW (CntW)
    ) u_lat_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (start_q),
        .lat       (start_lat),
        .free_next (cnt_free_next),
        .zero      (cnt_zero)
    );

    assign op_ok      = op_valid(req_op);
    assign req_accept = req_valid & ~flush & op_ok & (state_q != StRunP);
    // Unit can take a new start next cycle; a start this cycle always occupies it.
    assign unit_free  = ~start_q & (cnt_free_next | cnt_zero);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;

        unique case (state_q)
            StIdle: begin
                if (req_accept) begin
                    start_d = 1'b1;
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (req_accept) begin
                    if (unit_free) begin
                        // Back-to-back: skip the pending slot entirely.
                        start_d = 1'b1;
                        op_d    = req_op;
                        a_d     = req_a;
                        b_d     = req_b;
                    end else begin
                        pend_d  = '{op: req_op, a: req_a, b: req_b};
                        state_d = StRunP;
                    end
                end else if (unit_free) begin
                    state_d = StIdle;
                end
            end
            StRunP: begin
                if (unit_free) begin
                    start_d = 1'b1;
                    op_d    = pend_q.op;
                    a_d     = pend_q.a;
                    b_d     = pend_q.b;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pend_q  <= '0;
            start_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign md_start = start_q;
    assign md_op    = op_q;
    assign md_a     = a_q;
    assign md_b     = b_q;
    assign md_idle  = (state_q == StIdle);

    // A simultaneous req_valid/rd_req is illegal; the request takes precedence.
    assign stall = (req_valid & op_ok & (state_q == StRunP) & ~flush)
                 | (rd_req & ~req_valid & ~flush & ~md_idle);

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: a cycle-accurate schedule model (absolute start
// times per op) checked every cycle, plus hand-computed literal expectations.
module tb_md_sched;
    import md_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rd_req;
    logic        flush;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall;
    logic        md_idle;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int base   = 0;

    md_sched dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rd_req    (rd_req),
        .flush     (flush),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_a      (md_a),
        .md_b      (md_b),
        .stall     (stall),
        .md_idle   (md_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc - base, act, exp);
        end
    endtask

    // ---------------- schedule model ----------------
    typedef struct {
        int          st;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'd2, 3'd3: return 10;
            3'd4, 3'd5: return 1;
            default:    return 5;
        endcase
    endfunction

    initial begin
        ent_t        q[$];
        ent_t        e;
        int          free_all;
        logic [2:0]  h_op;
        logic [31:0] h_a, h_b;
        logic        e_start, pend_full, e_idle, e_stall;
        free_all = 0;
        h_op = '0;
        h_a  = '0;
        h_b  = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                q.delete();
                free_all = 0;
                h_op = '0;
                h_a  = '0;
                h_b  = '0;
            end else begin
                assert (!(req_valid && rd_req)) else $error("illegal req_valid with rd_req");
                e_start = 1'b0;
                if (q.size() > 0 && q[0].st == cyc) begin
                    e_start = 1'b1;
                    h_op = q[0].op;
                    h_a  = q[0].a;
                    h_b  = q[0].b;
                    void'(q.pop_front());
                end
                pend_full = (q.size() > 0);
                e_idle    = (cyc >= free_all);
                e_stall   = !flush && ((req_valid && req_op != 3'd7 && pend_full)
                                       || (rd_req && !e_idle));
                chk("model md_start", md_start, e_start);
                chk("model md_op",    md_op,    h_op);
                chk("model md_a",     md_a,     h_a);
                chk("model md_b",     md_b,     h_b);
                chk("model md_idle",  md_idle,  e_idle);
                chk("model stall",    stall,    e_stall);
                if (req_valid && !flush && req_op != 3'd7 && !pend_full) begin
                    e.st = (cyc + 1 > free_all) ? cyc + 1 : free_all;
                    e.op = req_op;
                    e.a  = req_a;
                    e.b  = req_b;
                    q.push_back(e);
                    free_all = e.st + lat_of(req_op) + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rd_req    = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
    endtask

    // Reset high in relative cycles 0 and 1; returns at the start of cycle 2.
    task automatic begin_scn();
        reset = 1'b1;
        idle_in();
        tick();
        base = cyc;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic scn_basic();
        begin_scn();
        for (int r = 2; r <= 12; r++) begin
            if (r > 2) tick();
            idle_in();
            if (r == 2) drive(OP_MULT, 32'd3, 32'hFFFF_FFFE);
            #1;
            if (r == 2) chk("s1 idle before start", md_idle, 1'b1);
            if (r == 3) begin
                chk("s1 start", md_start, 1'b1);
                chk("s1 op", md_op, 3'd0);
                chk("s1 a", md_a, 32'd3);
                chk("s1 b", md_b, 32'hFFFF_FFFE);
            end
            if (r == 4) chk("s1 start single pulse", md_start, 1'b0);
            if (r == 8) chk("s1 busy last", md_idle, 1'b0);
            if (r == 9) chk("s1 idle", md_idle, 1'b1);
        end
    endtask

    task automatic scn_pending(input logic with_mtlo);
        begin_scn();
        for (int r = 2; r <= 24; r++) begin
            if (r > 2) tick();
            idle_in();
            if (r == 2) drive(OP_MULT, 32'd3, 32'hFFFF_FFFE);
            if (r == 4) drive(OP_DIVU, 32'd100, 32'd7);
            if (!with_mtlo && r == 5) drive(3'd7, 32'd1, 32'd1);
            if (with_mtlo && r >= 5 && r <= 9) drive(OP_MTLO, 32'd55, 32'd0);
            #1;
            if (r == 4) chk("s2 pend no stall", stall, 1'b0);
            if (!with_mtlo) begin
                if (r == 5) chk("s2 op7 no stall", stall, 1'b0);
                if (r == 19) chk("s2 busy", md_idle, 1'b0);
                if (r == 20) chk("s2 idle", md_idle, 1'b1);
            end else begin
                if (r >= 5 && r <= 8) chk("s3 stall", stall, 1'b1);
                if (r == 9) chk("s3 drain accept", stall, 1'b0);
                if (r == 20) begin
                    chk("s3 mtlo start", md_start, 1'b1);
                    chk("s3 mtlo op", md_op, 3'd5);
                    chk("s3 mtlo a", md_a, 32'd55);
                end
                if (r == 21) chk("s3 busy", md_idle, 1'b0);
                if (r == 22) chk("s3 idle", md_idle, 1'b1);
            end
            if (r == 9) begin
                chk("s2 divu start", md_start, 1'b1);
                chk("s2 divu op", md_op, 3'd3);
                chk("s2 divu a", md_a, 32'd100);
            end
        end
    endtask

    task automatic scn_mflo();
        begin_scn();
        for (int r = 2; r <= 12; r++) begin
            if (r > 2) tick();
            idle_in();
            if (r == 2) drive(OP_MULT, 32'd4, 32'd5);
            if (r >= 4 && r <= 9) rd_req = 1'b1;
            #1;
            if (r >= 4 && r <= 8) chk("s4 mflo stall", stall, 1'b1);
            if (r == 9) chk("s4 mflo release", stall, 1'b0);
        end
    endtask

    task automatic scn_flush();
        begin_scn();
        for (int r = 2; r <= 16; r++) begin
            if (r > 2) tick();
            idle_in();
            if (r == 2) begin drive(OP_DIV, 32'd9, 32'd0); flush = 1'b1; end
            if (r == 5) drive(OP_MULT, 32'd7, 32'd8);
            if (r == 7) drive(OP_DIVU, 32'd9, 32'd3);
            if (r == 8) begin drive(OP_MULT, 32'd1, 32'd1); flush = 1'b1; end
            if (r == 9) begin rd_req = 1'b1; flush = 1'b1; end
            #1;
            if (r == 2) chk("s5 flush no stall", stall, 1'b0);
            if (r == 3) begin
                chk("s5 flush no start", md_start, 1'b0);
                chk("s5 flush idle", md_idle, 1'b1);
            end
            if (r == 8) chk("s5 flush req in RUN_P", stall, 1'b0);
            if (r == 9) chk("s5 flush read", stall, 1'b0);
            if (r == 12) begin
                chk("s5 pend start", md_start, 1'b1);
                chk("s5 pend op", md_op, 3'd3);
                chk("s5 pend a", md_a, 32'd9);
            end
        end
    endtask

    task automatic scn_reset();
        begin_scn();
        for (int r = 2; r <= 30; r++) begin
            if (r > 2) tick();
            idle_in();
            reset = (r == 5);
            if (r == 2) drive(OP_MULT, 32'd3, 32'd3);
            if (r == 4) drive(OP_DIVU, 32'd8, 32'd2);
            if (r >= 6 && r <= 10) rd_req = 1'b1;
            #1;
            if (r >= 6) begin
                chk("s6 no start after reset", md_start, 1'b0);
                chk("s6 idle after reset", md_idle, 1'b1);
                chk("s6 no stall after reset", stall, 1'b0);
            end
            if (r == 6) chk("s6 op cleared", md_op, 3'd0);
        end
    endtask

    task automatic scn_b2b();
        begin_scn();
        for (int r = 2; r <= 16; r++) begin
            if (r > 2) tick();
            idle_in();
            if (r == 2) drive(OP_MULT, 32'd1, 32'd2);
            if (r == 8) drive(OP_MSUB, 32'd5, 32'd6);
            #1;
            if (r == 8) chk("s7 b2b no stall", stall, 1'b0);
            if (r == 9) begin
                chk("s7 msub start", md_start, 1'b1);
                chk("s7 msub op", md_op, 3'd6);
                chk("s7 msub a", md_a, 32'd5);
                chk("s7 msub b", md_b, 32'd6);
            end
            if (r == 14) chk("s7 busy", md_idle, 1'b0);
            if (r == 15) chk("s7 idle", md_idle, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        scn_basic();
        scn_pending(1'b0);
        scn_pending(1'b1);
        scn_mflo();
        scn_flush();
        scn_reset();
        scn_b2b();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
